vector_mem_sequencer: RTL and testbench

Memory-stage sequencer that consumes the execute stage's vector results and moves one V-bit vector between the vector datapath and the N-bit data memory as V/N single-word beats. It serializes vector stores (lane 0 at the lowest address) and gathers vector loads into a V-bit register. It raises a stall to the hazard unit while a transfer is in flight and presents the assembled load result as the stage's ReadDataVM.

---
 rtl/vector_mem_sequencer_pkg.sv | 18 +
 rtl/vector_mem_sequencer_if.sv | 32 +++
 rtl/vector_mem_sequencer_lane_gather.sv | 27 ++
 rtl/vector_mem_sequencer.sv | 132 +++++++++++++
 tb/tb_vector_mem_sequencer.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/vector_mem_sequencer_pkg.sv
// Shared types and default geometry for the vector memory-stage sequencer.
package vector_mem_sequencer_pkg;

  localparam int unsigned DataW        = 32;
  localparam int unsigned VecW         = 256;
  localparam int unsigned Beats        = VecW / DataW;
  localparam int unsigned BeatIdxW     = $clog2(Beats);
  localparam int unsigned BytesPerWord = 4;

  typedef enum logic [2:0] {
    StIdle,
    StStore,
    StLoad,
    StLoadLast,
    StDone
  } vmem_state_t;

endpackage

// File: rtl/vector_mem_sequencer_if.sv
// Memory-stage vector op request, data-memory beat port and hazard/result signals.
interface vector_mem_sequencer_if #(
  parameter int unsigned N = 32,
  parameter int unsigned V = 256
);

  logic         StartM;
  logic         VecWriteM;
  logic [N-1:0] AddrM;
  logic [V-1:0] WriteDataVM;
  logic [N-1:0] MemAddr;
  logic [N-1:0] MemWData;
  logic         MemWE;
  logic         MemRE;
  logic [N-1:0] MemRData;
  logic [V-1:0] ReadDataVM;
  logic         DoneVM;
  logic         StallVM;
  logic         AlignErrM;

  // Pipeline plus data memory: issues ops, answers reads.
  modport master (
    output StartM, VecWriteM, AddrM, WriteDataVM, MemRData,
    input  MemAddr, MemWData, MemWE, MemRE, ReadDataVM, DoneVM, StallVM, AlignErrM
  );

  modport slave (
    input  StartM, VecWriteM, AddrM, WriteDataVM, MemRData,
    output MemAddr, MemWData, MemWE, MemRE, ReadDataVM, DoneVM, StallVM, AlignErrM
  );

endinterface

// File: rtl/vector_mem_sequencer_lane_gather.sv
// vector_lane_gather: V-bit load register assembled one N-bit lane at a time.
module vector_lane_gather #(
  parameter int unsigned N     = 32,
  parameter int unsigned Lanes = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [Lanes-1:0]   i_lane_we,
  input  logic [N-1:0]       i_wdata,
  output logic [N*Lanes-1:0] o_data
);

  logic [Lanes-1:0][N-1:0] r_lanes;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lanes <= '0;
    end else begin
      for (int i = 0; i < Lanes; i++) begin
        if (i_lane_we[i]) r_lanes[i] <= i_wdata;
      end
    end
  end

  assign o_data = r_lanes;

endmodule

// File: rtl/vector_mem_sequencer.sv
// Serializes a V-bit vector store into N-bit beats and gathers a vector load,
// stalling the pipeline while the transfer is in flight.
module vector_mem_sequencer
  import vector_mem_sequencer_pkg::*;
#(
  parameter int unsigned N = DataW,
  parameter int unsigned V = VecW
) (
  input logic                   clk,
  input logic                   rst,
  vector_mem_sequencer_if.slave bus
);

  localparam int unsigned NumBeats = V / N;
  localparam int unsigned IdxW     = $clog2(NumBeats);
  localparam int unsigned OffW     = $clog2(BytesPerWord);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NumBeats - 1);
  localparam logic [N-1:0]    WordMask = ~N'(BytesPerWord - 1);

  vmem_state_t   r_state;
  logic [IdxW-1:0] r_idx;
  logic [N-1:0]  r_base;
  logic [V-1:0]  r_data;
  logic [N-1:0]  r_mem_addr;
  logic [N-1:0]  r_mem_wdata;
  logic          r_mem_we;
  logic          r_mem_re;
  logic          r_done;
  logic          r_align_err;

  logic [IdxW-1:0]     w_next_idx;
  logic [N-1:0]        w_next_addr;
  logic [N-1:0]        w_accept_base;
  logic [NumBeats-1:0] w_lane_we;
  logic [V-1:0]        w_read_data;

  assign w_next_idx    = r_idx + 1'b1;
  assign w_accept_base = bus.AddrM & WordMask;
  // Wraps mod 2^N by construction of the N-bit add.
  assign w_next_addr   = r_base + ({{(N - IdxW){1'b0}}, w_next_idx} << OffW);

  // Read data returns one cycle after its strobe, so lane idx-1 lands while beat idx issues.
  always_comb begin
    w_lane_we = '0;
    if (r_state == StLoad && r_idx != '0) w_lane_we[r_idx - 1'b1] = 1'b1;
    if (r_state == StLoadLast) w_lane_we[NumBeats-1] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_base      <= '0;
      r_data      <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_done      <= 1'b0;
      r_align_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.StartM) begin
            r_base      <= w_accept_base;
            r_data      <= bus.WriteDataVM;
            r_idx       <= '0;
            r_align_err <= |(bus.AddrM & ~WordMask);
            r_mem_addr  <= w_accept_base;
            if (bus.VecWriteM) begin
              r_state     <= StStore;
              r_mem_we    <= 1'b1;
              r_mem_wdata <= bus.WriteDataVM[N-1:0];
            end else begin
              r_state  <= StLoad;
              r_mem_re <= 1'b1;
            end
          end
        end
        StStore: begin
          if (r_idx == LastIdx) begin
            r_state  <= StDone;
            r_mem_we <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_idx       <= w_next_idx;
            r_mem_addr  <= w_next_addr;
            r_mem_wdata <= r_data[N*w_next_idx +: N];
          end
        end
        StLoad: begin
          if (r_idx == LastIdx) begin
            r_state  <= StLoadLast;
            r_mem_re <= 1'b0;
          end else begin
            r_idx      <= w_next_idx;
            r_mem_addr <= w_next_addr;
          end
        end
        StLoadLast: begin
          r_state <= StDone;
          r_done  <= 1'b1;
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  vector_lane_gather #(
    .N     (N),
    .Lanes (NumBeats)
  ) u_gather (
    .clk       (clk),
    .rst       (rst),
    .i_lane_we (w_lane_we),
    .i_wdata   (bus.MemRData),
    .o_data    (w_read_data)
  );

  assign bus.StallVM    = (rst && r_state == StIdle && bus.StartM) ||
                          (r_state inside {StStore, StLoad, StLoadLast});
  assign bus.MemAddr    = r_mem_addr;
  assign bus.MemWData   = r_mem_wdata;
  assign bus.MemWE      = r_mem_we;
  assign bus.MemRE      = r_mem_re;
  assign bus.DoneVM     = r_done;
  assign bus.AlignErrM  = r_align_err;
  assign bus.ReadDataVM = w_read_data;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed bench for vector_mem_sequencer: vector table plus corner-case sequences.
module tb_vector_mem_sequencer;

  localparam int N = 32;
  localparam int V = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vector_mem_sequencer_if #(.N(N), .V(V)) vif ();

  vector_mem_sequencer #(.N(N), .V(V)) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif.slave)
  );

  typedef struct {
    bit          st;
    logic [31:0] addr;
    logic [255:0] wvec;
    logic [31:0] base;
    bit          align;
    int          lat;
    logic [255:0] rvec;
  } vec_t;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] ra_q[$];
  int done_cnt = 0;
  int both_hi  = 0;
  int checks   = 0;
  int passes   = 0;
  logic prev_align = 1'b0;
  vec_t vecs[5];

  always @(posedge clk) begin
    if (vif.MemWE) begin
      wa_q.push_back(vif.MemAddr);
      wd_q.push_back(vif.MemWData);
    end
    if (vif.MemRE) begin
      ra_q.push_back(vif.MemAddr);
      vif.MemRData <= mem.exists(vif.MemAddr) ? mem[vif.MemAddr] : 32'hDEADBEEF;
    end
    if (vif.MemWE && vif.MemRE) both_hi++;
    if (vif.DoneVM) done_cnt++;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mk(input logic [31:0] b, input logic [31:0] step);
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = b + step * i;
    return v;
  endfunction

  function automatic vec_t mkv(input bit st, input logic [31:0] addr, input logic [255:0] wvec,
                               input logic [31:0] base, input bit align, input int lat,
                               input logic [255:0] rvec);
    vec_t v;
    v.st = st; v.addr = addr; v.wvec = wvec; v.base = base;
    v.align = align; v.lat = lat; v.rvec = rvec;
    return v;
  endfunction

  task automatic run_op(input vec_t v, input string tag);
    int lat;
    bit stall_ok;
    int bad_addr;
    int bad_data;
    logic [31:0] ea;
    chk({tag, "_align_hold"}, 256'(vif.AlignErrM), 256'(prev_align));
    wa_q.delete(); wd_q.delete(); ra_q.delete();
    vif.StartM = 1'b1; vif.VecWriteM = v.st; vif.AddrM = v.addr; vif.WriteDataVM = v.wvec;
    #1;
    chk({tag, "_stall_accept"}, 256'(vif.StallVM), 256'(1));
    tick();
    vif.StartM = 1'b0;
    lat = 1;
    stall_ok = 1'b1;
    while (!vif.DoneVM && lat < 20) begin
      if (!vif.StallVM) stall_ok = 1'b0;
      tick();
      lat++;
    end
    chk({tag, "_done_latency"}, 256'(lat), 256'(v.lat));
    chk({tag, "_stall_held"}, 256'(stall_ok), 256'(1));
    chk({tag, "_stall_done"}, 256'(vif.StallVM), 256'(0));
    chk({tag, "_align"}, 256'(vif.AlignErrM), 256'(v.align));
    chk({tag, "_readdata"}, vif.ReadDataVM, v.rvec);
    chk({tag, "_writes"}, 256'(wa_q.size()), 256'(v.st ? 8 : 0));
    chk({tag, "_reads"}, 256'(ra_q.size()), 256'(v.st ? 0 : 8));
    bad_addr = 0;
    bad_data = 0;
    for (int i = 0; i < 8; i++) begin
      ea = v.base + 32'(4 * i);
      if (v.st) begin
        if (i >= wa_q.size() || wa_q[i] !== ea) bad_addr++;
        if (i >= wd_q.size() || wd_q[i] !== v.wvec[32*i +: 32]) bad_data++;
      end else begin
        if (i >= ra_q.size() || ra_q[i] !== ea) bad_addr++;
      end
    end
    chk({tag, "_beat_addr_errs"}, 256'(bad_addr), 256'(0));
    chk({tag, "_beat_data_errs"}, 256'(bad_data), 256'(0));
    tick();
    chk({tag, "_done_pulse"}, 256'(vif.DoneVM), 256'(0));
    prev_align = v.align;
  endtask

  initial begin
    int n;
    int d0;
    for (int i = 0; i < 8; i++) begin
      mem[32'h200 + 32'(4 * i)] = 32'hA0 + 32'(i);
      mem[32'h300 + 32'(4 * i)] = 32'hB0 + 32'(i);
    end
    vecs[0] = mkv(1'b1, 32'h0000_0100, mk(32'h1111_1111, 32'h1111_1111), 32'h0000_0100,
                  1'b0, 9, 256'h0);
    vecs[1] = mkv(1'b0, 32'h0000_0200, 256'h0, 32'h0000_0200, 1'b0, 10, mk(32'hA0, 32'h1));
    vecs[2] = mkv(1'b1, 32'hFFFF_FFF0, mk(32'h0102_0304, 32'h1000_0000), 32'hFFFF_FFF0,
                  1'b0, 9, mk(32'hA0, 32'h1));
    vecs[3] = mkv(1'b0, 32'h0000_0203, 256'h0, 32'h0000_0200, 1'b1, 10, mk(32'hA0, 32'h1));
    vecs[4] = mkv(1'b0, 32'h0000_0300, 256'h0, 32'h0000_0300, 1'b0, 10, mk(32'hB0, 32'h1));

    // Reset state, with StartM high to confirm it is ignored under reset.
    vif.StartM = 1'b1; vif.VecWriteM = 1'b1; vif.AddrM = 32'h0; vif.WriteDataVM = '0;
    #12;
    chk("reset_outputs", 256'({vif.MemWE, vif.MemRE, vif.DoneVM, vif.StallVM, vif.AlignErrM,
                              vif.MemAddr, vif.MemWData}), 256'(0));
    chk("reset_readdata", vif.ReadDataVM, 256'h0);
    vif.StartM = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();

    for (int k = 0; k < 5; k++) run_op(vecs[k], $sformatf("vec%0d", k));

    // StartM during STORE and during DONE must be ignored.
    wa_q.delete(); wd_q.delete(); ra_q.delete();
    d0 = done_cnt;
    vif.StartM = 1'b1; vif.VecWriteM = 1'b1; vif.AddrM = 32'h400; vif.WriteDataVM = mk(32'hC0, 1);
    tick();
    vif.StartM = 1'b0;
    tick();
    tick();
    vif.StartM = 1'b1; vif.VecWriteM = 1'b0; vif.AddrM = 32'h500;
    tick();
    vif.StartM = 1'b0;
    n = 0;
    while (!vif.DoneVM && n < 20) begin
      tick();
      n++;
    end
    chk("ign_done_seen", 256'(vif.DoneVM), 256'(1));
    vif.StartM = 1'b1;
    #1;
    chk("ign_stall_in_done", 256'(vif.StallVM), 256'(0));
    tick();
    vif.StartM = 1'b0;
    repeat (12) tick();
    chk("ign_writes", 256'(wa_q.size()), 256'(8));
    chk("ign_reads", 256'(ra_q.size()), 256'(0));
    chk("ign_single_done", 256'(done_cnt - d0), 256'(1));
    chk("ign_last_addr", 256'(wa_q.size() == 8 ? wa_q[7] : 32'hX), 256'(32'h41C));
    chk("ign_last_data", 256'(wd_q.size() == 8 ? wd_q[7] : 32'hX), 256'(32'hC7));

    // Asynchronous reset during beat 3 of a store.
    wa_q.delete(); wd_q.delete(); ra_q.delete();
    vif.StartM = 1'b1; vif.VecWriteM = 1'b1; vif.AddrM = 32'h600; vif.WriteDataVM = mk(32'hD0, 1);
    tick();
    vif.StartM = 1'b0;
    tick();
    tick();
    tick();
    chk("rst_beat3_addr", 256'(vif.MemAddr), 256'(32'h60C));
    #2;
    rst = 1'b0;
    vif.StartM = 1'b1;
    #1;
    chk("rst_async_outputs", 256'({vif.MemWE, vif.MemRE, vif.DoneVM, vif.StallVM, vif.AlignErrM,
                                  vif.MemAddr, vif.MemWData}), 256'(0));
    chk("rst_async_readdata", vif.ReadDataVM, 256'h0);
    tick();
    chk("rst_held_outputs", 256'({vif.MemWE, vif.MemRE, vif.DoneVM, vif.StallVM}), 256'(0));
    vif.StartM = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst_idle", 256'({vif.MemWE, vif.MemRE, vif.StallVM, vif.DoneVM}), 256'(0));
    chk("rst_partial_writes", 256'(wa_q.size()), 256'(3));
    prev_align = 1'b0;
    run_op(mkv(1'b0, 32'h200, 256'h0, 32'h200, 1'b0, 10, mk(32'hA0, 32'h1)), "post_rst");

    chk("exclusive_strobes", 256'(both_hi), 256'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
